ticket_vend_ctrl: RTL and testbench
===================================

TICKET_VEND_CTRL -- requirements
Module: ticket_vend_ctrl

Interface
REQ-001 The block SHALL have parameter PRICE, default 3, meaning ticket price in nickel units (1..15).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning idle cycles in COLLECT before auto-refund (1..255).
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port coin_valid  input  1  one-cycle strobe, coin present this cycle.
REQ-006 The block SHALL have port coin  input  2  coin code: 0 penny, 1 nickel, 2 dime, 3 reserved.
REQ-007 The block SHALL have port cancel  input  1  customer abort request, level-sampled.
REQ-008 The block SHALL have port dispense_ack  input  1  dispenser mechanism has issued the ticket.
REQ-009 The block SHALL have port refund_ack  input  1  coin return mechanism has paid out refund_nickels.
REQ-010 The block SHALL have port dispense_req  output  1  request to the dispenser, held until acknowledged.
REQ-011 The block SHALL have port ticket_done  output  1  one-cycle pulse per completed ticket.
REQ-012 The block SHALL have port refund_req  output  1  request to the coin return, held until acknowledged.
REQ-013 The block SHALL have port refund_nickels  output  4  amount to return, stable while refund_req is high.
REQ-014 The block SHALL have port reject  output  1  one-cycle pulse when an offered coin is not credited.
REQ-015 The block SHALL have port credit  output  4  current accumulated credit in nickel units.

Function
REQ-016 The FSM SHALL have states IDLE, COLLECT, DISPENSE, REFUND.
REQ-017 Credit values SHALL be nickel 1, dime 2; penny and code 3 SHALL be rejected (reject pulse next cycle, credit unchanged).
REQ-018 A valid coin in IDLE or COLLECT SHALL add to credit on the same edge, saturating at 15; IDLE moves to COLLECT.
REQ-019 When the updated credit is >= PRICE, the FSM SHALL enter DISPENSE on that edge; dispense_req SHALL rise the cycle after the final coin.
REQ-020 Any coin offered in DISPENSE or REFUND SHALL be rejected and not credited.
REQ-021 In DISPENSE, dispense_req SHALL remain high until dispense_ack is sampled high; cancel SHALL be ignored.
REQ-022 On dispense_ack, ticket_done SHALL pulse the next cycle; excess = credit - PRICE.
REQ-023 A cycle-counter SHALL reset on each coin in COLLECT; reaching TIMEOUT SHALL enter REFUND with the full credit.
REQ-024 Cancel high in COLLECT SHALL enter REFUND with the full credit; cancel in IDLE SHALL be a no-op.
REQ-025 Coin and cancel on the same edge in COLLECT: cancel SHALL win and the coin SHALL be rejected.
REQ-026 In REFUND, refund_req SHALL stay high with refund_nickels constant until refund_ack; then credit SHALL clear and FSM returns to IDLE.
REQ-027 Acks sampled while the corresponding request is low SHALL be ignored.

Reset
REQ-028 Asserting rst low SHALL immediately force IDLE, credit 0, timeout counter 0, and all outputs 0, including mid-dispense or mid-refund.
REQ-029 After rst release, the first rising clk edge SHALL be a normal IDLE cycle.

Configuration
REQ-030 With macro TICKET_VEND_CHANGE_RETURN_EN defined, nonzero excess after a ticket SHALL go to REFUND with refund_nickels = excess.
REQ-031 Without TICKET_VEND_CHANGE_RETURN_EN, excess SHALL be forfeited: after a ticket, credit clears and FSM returns to IDLE. Cancel/timeout refunds SHALL remain in both builds.

Verification
REQ-032 PRICE=3: nickel, dime -> credit 1 then 3, dispense_req high; ack -> ticket_done pulse, credit 0, IDLE.
REQ-033 PRICE=3, macro on: dime, dime -> credit 4, dispense; after ack -> refund_req, refund_nickels=1; refund_ack -> IDLE.
REQ-034 Same stimulus with macro off -> no refund_req; IDLE one cycle after ticket_done.
REQ-035 Penny, then code 3 -> two reject pulses, credit stays 0, state IDLE; dime during DISPENSE -> reject.
REQ-036 TIMEOUT=4: nickel then 4 idle cycles -> refund_req, refund_nickels=1; cancel+coin same edge -> refund of prior credit, coin rejected.
REQ-037 Assert rst during DISPENSE with dispense_req high -> dispense_req, credit low immediately, no ticket_done.

Source files
------------

// File: rtl/ticket_vend_ctrl_if.sv
// Customer-facing bundle of the ticket vending controller: coin entry, cancel,
// dispenser and coin-return handshakes, plus status outputs.
// Ports: slave = controller side (drives requests/status), master = mechanism/customer side.
interface ticket_vend_ctrl_if;
  logic       coin_valid;      // one-cycle strobe, coin present
  logic [1:0] coin;            // 0 penny, 1 nickel, 2 dime, 3 reserved
  logic       cancel;          // customer abort, level-sampled
  logic       dispense_ack;    // dispenser has issued the ticket
  logic       refund_ack;      // coin return has paid out refund_nickels
  logic       dispense_req;    // held until dispense_ack
  logic       ticket_done;     // one-cycle pulse per ticket
  logic       refund_req;      // held until refund_ack
  logic [3:0] refund_nickels;  // stable while refund_req is high
  logic       reject;          // one-cycle pulse per uncredited coin
  logic [3:0] credit;          // accumulated credit in nickels

  modport slave (
    input  coin_valid, coin, cancel, dispense_ack, refund_ack,
    output dispense_req, ticket_done, refund_req, refund_nickels, reject, credit
  );

  modport master (
    output coin_valid, coin, cancel, dispense_ack, refund_ack,
    input  dispense_req, ticket_done, refund_req, refund_nickels, reject, credit
  );
endinterface

// File: rtl/ticket_vend_ctrl.sv
// Ticket vending controller: accumulates nickel/dime credit, requests a ticket
// once credit reaches PRICE, and refunds credit on cancel or inactivity timeout.
// Ports: clk, rst (async active-low), vif (ticket_vend_ctrl_if.slave).
// Optional build macro TICKET_VEND_CHANGE_RETURN_EN: excess credit after a
// ticket is returned through the refund handshake instead of being forfeited.
module ticket_vend_ctrl #(
  parameter int unsigned PRICE   = 3,    // ticket price in nickels, 1..15
  parameter int unsigned TIMEOUT = 255   // idle COLLECT cycles before refund, 1..255
) (
  input  logic                 clk,
  input  logic                 rst,
  ticket_vend_ctrl_if.slave    vif
);

  localparam logic [3:0] PRICE_C   = 4'(PRICE);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  localparam logic [1:0] COIN_NICKEL = 2'd1;
  localparam logic [1:0] COIN_DIME   = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    REFUND   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic [7:0] tmo_q, tmo_d;
  logic [3:0] refund_q, refund_d;
  logic       reject_q, reject_d;
  logic       done_q, done_d;

  // Coin decode and saturating credit sum (prior credit < PRICE, so one
  // extra bit is enough to detect overflow past 15).
  logic       coin_ok;
  logic [4:0] coin_val;
  logic [4:0] sum;
  logic [3:0] sat_credit;
  logic [7:0] tmo_inc;

  assign coin_ok    = (vif.coin == COIN_NICKEL) || (vif.coin == COIN_DIME);
  assign coin_val   = (vif.coin == COIN_DIME) ? 5'd2 : 5'd1;
  assign sum        = {1'b0, credit_q} + coin_val;
  assign sat_credit = (sum > 5'd15) ? 4'hF : sum[3:0];
  assign tmo_inc    = tmo_q + 8'd1;

`ifdef TICKET_VEND_CHANGE_RETURN_EN
  logic [3:0] excess;
  assign excess = credit_q - PRICE_C;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      credit_q <= 4'd0;
      tmo_q    <= 8'd0;
      refund_q <= 4'd0;
      reject_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      tmo_q    <= tmo_d;
      refund_q <= refund_d;
      reject_q <= reject_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    tmo_d    = tmo_q;
    refund_d = refund_q;
    reject_d = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // cancel is meaningless with no credit, so it is ignored here
        tmo_d    = 8'd0;
        refund_d = 4'd0;
        if (vif.coin_valid) begin
          if (coin_ok) begin
            credit_d = sat_credit;
            state_d  = (sat_credit >= PRICE_C) ? DISPENSE : COLLECT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      COLLECT: begin
        if (vif.cancel) begin
          // cancel beats a coin offered on the same edge
          state_d  = REFUND;
          refund_d = credit_q;
          tmo_d    = 8'd0;
          reject_d = vif.coin_valid;
        end else if (vif.coin_valid && coin_ok) begin
          credit_d = sat_credit;
          tmo_d    = 8'd0;
          if (sat_credit >= PRICE_C) begin
            state_d = DISPENSE;
          end
        end else begin
          // a rejected coin does not count as customer activity
          reject_d = vif.coin_valid;
          if (tmo_inc == TIMEOUT_C) begin
            state_d  = REFUND;
            refund_d = credit_q;
            tmo_d    = 8'd0;
          end else begin
            tmo_d = tmo_inc;
          end
        end
      end

      DISPENSE: begin
        reject_d = vif.coin_valid;
        if (vif.dispense_ack) begin
          done_d = 1'b1;
`ifdef TICKET_VEND_CHANGE_RETURN_EN
          if (excess != 4'd0) begin
            // remaining credit shows the change being paid back
            state_d  = REFUND;
            refund_d = excess;
            credit_d = excess;
          end else begin
            state_d  = IDLE;
            credit_d = 4'd0;
          end
`else
          state_d  = IDLE;
          credit_d = 4'd0;
`endif
        end
      end

      REFUND: begin
        reject_d = vif.coin_valid;
        if (vif.refund_ack) begin
          state_d  = IDLE;
          credit_d = 4'd0;
          refund_d = 4'd0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Requests are decoded from state so reset drops them immediately.
  assign vif.dispense_req   = (state_q == DISPENSE);
  assign vif.refund_req     = (state_q == REFUND);
  assign vif.refund_nickels = refund_q;
  assign vif.ticket_done    = done_q;
  assign vif.reject         = reject_q;
  assign vif.credit         = credit_q;

endmodule

// File: tb/tb_ticket_vend_ctrl.sv
// Self-checking bench for ticket_vend_ctrl (PRICE=3, TIMEOUT=4): directed
// scenarios followed by randomized coins/cancels/acks/resets, all compared
// against a transaction-level model of credit, pending ticket and pending refund.
module tb_ticket_vend_ctrl;

  localparam int P_PRICE = 3;
  localparam int P_TMO   = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  ticket_vend_ctrl_if bus ();

  ticket_vend_ctrl #(.PRICE(P_PRICE), .TIMEOUT(P_TMO)) dut (
    .clk (clk),
    .rst (rst),
    .vif (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: credit held, ticket owed, refund amount owed (0 = none), idle cycles.
  int m_credit;
  bit m_disp;
  int m_refund;
  int m_idle;
  bit e_rej;
  bit e_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_disp = 0; m_refund = 0; m_idle = 0; e_rej = 0; e_done = 0;
  endtask

  task automatic model_step(input bit cv, input int c, input bit can, input bit dack, input bit rack);
    int val;
    int exc;
    bit collecting;
    e_rej  = 0;
    e_done = 0;
    val    = (cv && c == 1) ? 1 : (cv && c == 2) ? 2 : 0;
    if (m_disp) begin
      e_rej = cv;
      if (dack) begin
        e_done = 1;
        m_disp = 0;
        exc    = m_credit - P_PRICE;
`ifdef TICKET_VEND_CHANGE_RETURN_EN
        m_refund = exc;
        m_credit = exc;
`else
        m_credit = 0;
`endif
      end
    end else if (m_refund > 0) begin
      e_rej = cv;
      if (rack) begin
        m_refund = 0;
        m_credit = 0;
      end
    end else begin
      collecting = (m_credit > 0);
      if (collecting && can) begin
        e_rej    = cv;
        m_refund = m_credit;
      end else if (val > 0) begin
        m_credit = (m_credit + val > 15) ? 15 : m_credit + val;
        m_idle   = 0;
        if (m_credit >= P_PRICE) m_disp = 1;
      end else begin
        e_rej = cv;
        if (collecting) begin
          m_idle++;
          if (m_idle == P_TMO) begin
            m_refund = m_credit;
            m_idle   = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".credit"}, 32'(bus.credit), m_credit);
    check({tag, ".disp_req"}, 32'(bus.dispense_req), 32'(m_disp));
    check({tag, ".ref_req"}, 32'(bus.refund_req), 32'(m_refund > 0));
    check({tag, ".ref_nk"}, 32'(bus.refund_nickels), m_refund);
    check({tag, ".reject"}, 32'(bus.reject), 32'(e_rej));
    check({tag, ".done"}, 32'(bus.ticket_done), 32'(e_done));
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare at edge+1.
  task automatic cyc(input string tag, input bit cv, input int c, input bit can,
                     input bit dack, input bit rack);
    bus.coin_valid   = cv;
    bus.coin         = 2'(c);
    bus.cancel       = can;
    bus.dispense_ack = dack;
    bus.refund_ack   = rack;
    @(posedge clk);
    model_step(cv, c, can, dack, rack);
    #1;
    check_all(tag);
  endtask

  // Mid-cycle asynchronous reset: outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    model_reset();
    rst = 1'b0;
    bus.coin_valid = 0; bus.coin = 0; bus.cancel = 0;
    bus.dispense_ack = 0; bus.refund_ack = 0;
    #12;
    check_all("reset");
    rst = 1'b1;

    // nickel, dime -> 1 then 3, dispense; ack -> ticket, credit 0
    cyc("c32a", 1, 1, 0, 0, 0);
    check("c32_cr1", 32'(bus.credit), 1);
    cyc("c32b", 1, 2, 0, 0, 0);
    check("c32_cr3", 32'(bus.credit), 3);
    check("c32_dreq", 32'(bus.dispense_req), 1);
    cyc("c32c", 0, 0, 0, 0, 0);
    cyc("c32d", 0, 0, 0, 1, 0);
    check("c32_done", 32'(bus.ticket_done), 1);
    check("c32_cr0", 32'(bus.credit), 0);
    cyc("c32e", 0, 0, 0, 0, 0);
    check("c32_done_pulse", 32'(bus.ticket_done), 0);

    // dime, dime -> credit 4; change handling depends on build
    cyc("c33a", 1, 2, 0, 0, 0);
    cyc("c33b", 1, 2, 0, 0, 0);
    check("c33_cr4", 32'(bus.credit), 4);
    cyc("c33c", 0, 0, 0, 1, 0);
`ifdef TICKET_VEND_CHANGE_RETURN_EN
    check("c33_rreq", 32'(bus.refund_req), 1);
    check("c33_rnk", 32'(bus.refund_nickels), 1);
    cyc("c33d", 0, 0, 0, 0, 1);
    check("c33_rdone", 32'(bus.refund_req), 0);
`else
    check("c34_norreq", 32'(bus.refund_req), 0);
    check("c34_cr0", 32'(bus.credit), 0);
`endif
    cyc("c33e", 0, 0, 0, 0, 0);

    // penny and code 3 rejected in IDLE; dime rejected during DISPENSE
    cyc("c35a", 1, 0, 0, 0, 0);
    check("c35_rej_penny", 32'(bus.reject), 1);
    cyc("c35b", 1, 3, 0, 0, 0);
    check("c35_rej_code3", 32'(bus.reject), 1);
    check("c35_cr0", 32'(bus.credit), 0);
    cyc("c35c", 0, 0, 1, 1, 1);   // cancel/acks in IDLE: no effect
    cyc("c35d", 1, 1, 0, 0, 0);
    cyc("c35e", 1, 2, 0, 0, 0);
    cyc("c35f", 1, 2, 1, 0, 0);   // dime + cancel while dispensing
    check("c35_rej_disp", 32'(bus.reject), 1);
    check("c35_cr_disp", 32'(bus.credit), 3);
    cyc("c35g", 0, 0, 0, 1, 0);
    cyc("c35h", 0, 0, 0, 0, 0);

    // timeout: nickel then 4 idle cycles -> refund of 1
    cyc("c36a", 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("c36idle", 0, 0, 0, 0, 0);
    check("c36_rreq", 32'(bus.refund_req), 1);
    check("c36_rnk", 32'(bus.refund_nickels), 1);
    cyc("c36b", 1, 1, 0, 0, 0);   // coin during refund rejected
    cyc("c36c", 0, 0, 0, 0, 1);
    // cancel + coin on the same edge: refund prior credit, coin rejected
    cyc("c36d", 1, 1, 0, 0, 0);
    cyc("c36e", 1, 1, 1, 0, 0);
    check("c36_can_rnk", 32'(bus.refund_nickels), 1);
    check("c36_can_rej", 32'(bus.reject), 1);
    cyc("c36f", 0, 0, 0, 0, 1);

    // reset while dispensing: request and credit drop at once, no ticket
    cyc("c37a", 1, 1, 0, 0, 0);
    cyc("c37b", 1, 2, 0, 0, 0);
    do_reset("c37rst");
    check("c37_dreq", 32'(bus.dispense_req), 0);
    cyc("c37c", 0, 0, 0, 1, 0);
    check("c37_nodone", 32'(bus.ticket_done), 0);

    // randomized traffic including spurious acks and occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic cv, can, dack, rack;
      int   c;
      cv   = ($urandom_range(0, 2) == 0);
      c    = $urandom_range(0, 3);
      can  = ($urandom_range(0, 15) == 0);
      dack = bus.dispense_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      rack = bus.refund_req   ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
      else cyc("rnd", cv, c, can, dack, rack);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
